// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: turns descriptors into 32-bit words and streams
// them through a small FIFO into consecutive instruction-memory addresses.
module instr_encoder #(
   parameter int AW    = 10,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_last,
   input  logic [4:0]    op_sel,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [4:0]    shamt,
   input  logic [15:0]   imm,
   input  logic [25:0]   target,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   input  logic          imem_ready,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   count,
   output logic [1:0]    dbg_state_o
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Handshakes: a descriptor transfers on the rising edge where in_valid && in_ready;
   // an imem write completes on the rising edge where imem_we && imem_ready.
   state_t        state_q;
   logic [PW:0]   wr_ptr_q;
   logic [PW:0]   rd_ptr_q;
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] addr_q;
   logic [AW:0]   count_q;
   logic          err_q;

   logic          fifo_empty;
   logic          fifo_full;
   logic          accept;
   logic          pop;
   logic          legal;
   logic          shift_op;
   logic [5:0]    funct;
   logic [5:0]    opcode;
   logic [31:0]   enc_word;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

   assign in_ready    = (state_q == S_RUN) && !fifo_full;
   assign accept      = in_valid && in_ready;
   assign pop         = !fifo_empty && imem_ready;

   assign imem_we     = !fifo_empty;
   assign imem_wdata  = mem_q[rd_ptr_q[PW-1:0]];
   assign imem_addr   = addr_q;
   assign count       = count_q;
   assign err         = err_q;
   assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DONE);
   assign dbg_state_o = state_q;

   always_comb begin
      legal    = 1'b1;
      shift_op = 1'b0;
      funct    = 6'd0;
      opcode   = 6'd0;
      enc_word = 32'd0;
      case (op_sel)
         5'd0:  funct = 6'b100000;
         5'd1:  funct = 6'b100001;
         5'd2:  funct = 6'b100010;
         5'd3:  funct = 6'b100011;
         5'd4:  funct = 6'b100100;
         5'd5:  funct = 6'b100101;
         5'd6:  funct = 6'b100110;
         5'd7:  funct = 6'b100111;
         5'd8:  funct = 6'b101010;
         5'd9:  funct = 6'b101011;
         5'd10: begin funct = 6'b000000; shift_op = 1'b1; end
         5'd11: begin funct = 6'b000010; shift_op = 1'b1; end
         5'd12: begin funct = 6'b000011; shift_op = 1'b1; end
         5'd13: funct = 6'b000100;
         5'd14: funct = 6'b000110;
         5'd15: funct = 6'b000111;
         5'd16: opcode = 6'b001000;
         5'd17: opcode = 6'b001001;
         5'd18: opcode = 6'b001100;
         5'd19: opcode = 6'b001101;
         5'd20: opcode = 6'b001110;
         5'd21: opcode = 6'b100011;
         5'd22: opcode = 6'b101011;
         5'd23: opcode = 6'b000100;
         5'd24: opcode = 6'b000101;
         5'd25: opcode = 6'b001111;
         5'd26: opcode = 6'b001010;
         5'd27: opcode = 6'b001011;
         5'd28: opcode = 6'b000010;
         default: legal = 1'b0;
      endcase
      // Immediate shifts carry their amount in shamt, so rs is zeroed; others zero shamt.
      if (op_sel < 5'd16) begin
         if (shift_op) enc_word = {6'b000000, 5'd0, rt, rd, shamt, funct};
         else          enc_word = {6'b000000, rs, rt, rd, 5'd0, funct};
      end else if (op_sel == 5'd28) begin
         enc_word = {opcode, target};
      end else if (op_sel == 5'd25) begin
         enc_word = {opcode, 5'd0, rt, imm};
      end else begin
         enc_word = {opcode, rs, rt, imm};
      end
   end

   // Storage has no reset: occupancy is defined solely by the pointers.
   always_ff @(posedge clk) begin
      if (accept && legal) mem_q[wr_ptr_q[PW-1:0]] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         addr_q   <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept && legal) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            addr_q   <= addr_q + 1'b1;
            count_q  <= count_q + 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  addr_q  <= base_addr;
                  count_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (!legal) err_q <= 1'b1;
                  if (in_last) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table-driven encoding model feeds an expected
// word queue that a per-cycle compare process checks against every imem write.
module tb_instr_encoder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  localparam logic [5:0] FUNCT_TAB [16] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] OPC_TAB [13] = '{
    6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04,
    6'h05, 6'h0F, 6'h0A, 6'h0B, 6'h02};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [4:0]    op_sel = '0;
  logic [4:0]    rs = '0;
  logic [4:0]    rt = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    shamt = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;
  logic [1:0]    dbg_state_o;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .target(target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .err(err),
    .count(count), .dbg_state_o(dbg_state_o));

  // scoreboard
  logic [31:0]   exp_q[$];
  logic [AW-1:0] model_addr = '0;
  int            total = 0;
  int            bad = 0;
  int            rdy_mode = 0;
  int            cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {legal, word}
  function automatic logic [32:0] enc_model(input logic [4:0] op, input logic [4:0] a_rs,
      input logic [4:0] a_rt, input logic [4:0] a_rd, input logic [4:0] a_sh,
      input logic [15:0] a_imm, input logic [25:0] a_tgt);
    logic [31:0] w;
    int          n;
    bit          sh_op;
    n = int'(op);
    w = 32'd0;
    if (n < 16) begin
      sh_op = (n >= 10 && n <= 12);
      w = (32'(sh_op ? 5'd0 : a_rs) << 21) | (32'(a_rt) << 16) | (32'(a_rd) << 11) |
          (32'(sh_op ? a_sh : 5'd0) << 6) | 32'(FUNCT_TAB[n]);
      return {1'b1, w};
    end else if (n == 28) begin
      w = (32'(OPC_TAB[12]) << 26) | 32'(a_tgt);
      return {1'b1, w};
    end else if (n <= 27) begin
      w = (32'(OPC_TAB[n-16]) << 26) | (32'(n == 25 ? 5'd0 : a_rs) << 21) |
          (32'(a_rt) << 16) | 32'(a_imm);
      return {1'b1, w};
    end
    return {1'b0, 32'd0};
  endfunction

  // imem_ready pattern: 0 = always ready, 1 = ready two of every three cycles, 2 = stalled
  initial forever begin
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      0:       imem_ready = 1'b1;
      1:       imem_ready = (cyc % 3) != 0;
      default: imem_ready = 1'b0;
    endcase
  end

  // compare process
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      check("rst_we", imem_we, 0);
      check("rst_in_ready", in_ready, 0);
    end else begin
      if (in_ready && !busy) check("in_ready_idle", in_ready, 0);
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", imem_wdata, 32'hDEAD_BEEF);
        end else begin
          check("wr_data", imem_wdata, exp_q.pop_front());
          check("wr_addr", 32'(imem_addr), 32'(model_addr));
        end
        model_addr = model_addr + 1'b1;
      end
    end
  end

  // driver tasks (entered and left at a falling edge)
  task automatic start_session(input logic [AW-1:0] b);
    start = 1'b1;
    base_addr = b;
    model_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic model_accept();
    logic [32:0] r;
    r = enc_model(op_sel, rs, rt, rd, shamt, imm, target);
    if (r[32]) exp_q.push_back(r[31:0]);
  endtask

  task automatic send_cur(input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_last = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      model_accept();
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send(input logic [4:0] a_op, input logic [4:0] a_rs, input logic [4:0] a_rt,
      input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [15:0] a_imm,
      input logic [25:0] a_tgt, input logic last);
    op_sel = a_op; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh;
    imm = a_imm; target = a_tgt;
    send_cur(last);
  endtask

  task automatic set_fields(input int i);
    op_sel = 5'(i % 29);
    rs = 5'(i); rt = 5'(31 - i); rd = 5'(i * 3); shamt = 5'(i * 7);
    imm = 16'(16'h1000 + i * 16'h0111);
    target = 26'(26'h155_5555 ^ i);
  endtask

  task automatic wait_done(input string tag, input int exp_count, input logic exp_err);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_state_idle"}, dbg_state_o, 0);
  endtask

  initial begin
    int acc;
    int idx;

    // pin the model with hand-encoded words
    check("pin_add",  enc_model(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0), {1'b1, 32'h0022_1820});
    check("pin_addi", enc_model(5'd16, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0), {1'b1, 32'h2008_FFFF});
    check("pin_lui",  enc_model(5'd25, 5'd5, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0), {1'b1, 32'h3C09_1234});
    check("pin_j",    enc_model(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40), {1'b1, 32'h0800_0040});
    check("pin_sll",  enc_model(5'd10, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0), {1'b1, 32'h0002_1900});
    check("pin_sw",   enc_model(5'd22, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'h0), {1'b1, 32'hAFBF_0010});

    // reset state
    repeat (3) @(negedge clk);
    check("reset_we", imem_we, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_addr", 32'(imem_addr), 0);
    check("reset_count", 32'(count), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_state", dbg_state_o, 0);
    rst_n = 1'b1;
    #1;
    check("post_release_we", imem_we, 0);
    @(negedge clk);

    // single ADD
    start_session(10'h010);
    check("run_busy", busy, 1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done("add", 1, 1'b0);
    check("add_final_addr", 32'(imem_addr), 32'h011);

    // ADDI, LUI, J
    start_session(10'h020);
    send(5'd16, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    send(5'd25, 5'd5, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    send(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b1);
    wait_done("itype", 3, 1'b0);

    // every legal op under a stuttering memory
    rdy_mode = 1;
    start_session(10'h100);
    for (int i = 0; i < 29; i++) begin
      set_fields(i);
      send_cur(i == 28);
    end
    wait_done("all_ops", 29, 1'b0);
    rdy_mode = 0;

    // backpressure: memory stalled for 10 cycles, descriptors offered every cycle
    rdy_mode = 2;
    start_session(10'h200);
    acc = 0;
    idx = 0;
    set_fields(idx);
    in_valid = 1'b1;
    repeat (10) begin
      if (in_ready) begin
        model_accept();
        idx++;
        acc++;
        @(negedge clk);
        set_fields(idx);
      end else begin
        @(negedge clk);
      end
    end
    check("bp_accepts", 32'(acc), DEPTH);
    check("bp_in_ready_low", in_ready, 0);
    rdy_mode = 0;
    send_cur(1'b0);
    set_fields(idx + 1);
    send_cur(1'b1);
    wait_done("backpressure", DEPTH + 2, 1'b0);

    // address wrap
    start_session(10'h3FF);
    send(5'd5, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 16'hA5A5, 26'h0, 1'b1);
    wait_done("wrap", 2, 1'b0);
    check("wrap_final_addr", 32'(imem_addr), 32'h001);

    // illegal op
    start_session(10'h050);
    send(5'd30, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done("illegal", 0, 1'b1);
    check("illegal_err_sticky", err, 1);
    start_session(10'h060);
    check("err_cleared_on_start", err, 0);
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd1, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done("illegal_mixed", 1, 1'b1);

    // reset mid-session with words buffered
    rdy_mode = 2;
    start_session(10'h080);
    send(5'd2, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd17, 5'd2, 5'd3, 5'd0, 5'd0, 16'h7777, 26'h0, 1'b0);
    send(5'd26, 5'd4, 5'd5, 5'd0, 5'd0, 16'h8888, 26'h0, 1'b0);
    check("mid_we_buffered", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_addr", 32'(imem_addr), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_we", imem_we, 0);
    start_session(10'h090);
    send(5'd13, 5'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
    send(5'd24, 5'd10, 5'd11, 5'd0, 5'd0, 16'hFFFE, 26'h0, 1'b1);
    wait_done("after_rst", 2, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter AW, default 10, imem word-address width.
REQ-002 Parameter DEPTH, default 4, encoded-word FIFO depth (power of two, >=2).
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a load session at base_addr.
REQ-006 base_addr  input  AW  first imem word address of the session.
REQ-007 in_valid  input  1  instruction descriptor valid.
REQ-008 in_ready  output  1  encoder accepts descriptor this cycle.
REQ-009 in_last  input  1  descriptor is the final one of the session.
REQ-010 op_sel  input  5  instruction enumeration (REQ-016).
REQ-011 rs, rt, rd, shamt  input  5 each  register/shift fields.
REQ-012 imm  input  16  immediate / branch offset; target  input  26  jump target.
REQ-013 imem_we  output  1  write strobe; imem_addr  output  AW; imem_wdata  output  32.
REQ-014 imem_ready  input  1  memory accepts the write this cycle.
REQ-015 busy  output  1; done  output  1 (one-cycle pulse); err  output  1 (sticky); count  output  AW+1  words written this session.

Function
REQ-016 op_sel encoding: 0-15 = R-type opcode 000000 with funct ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111; 16-28 = opcode ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101, LUI 001111, SLTI 001010, SLTIU 001011, J 000010; 29-31 illegal.
REQ-017 R-type word = {000000, rs, rt, rd, shamt, funct}; SLL/SRL/SRA force rs=0; all other R-type force shamt=0.
REQ-018 I-type word = {opcode, rs, rt, imm}; LUI forces rs=0; J word = {000010, target}.
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE: start -> RUN, write pointer <= base_addr, count <= 0, err <= 0; in_ready=0 in IDLE, DRAIN, DONE.
REQ-021 RUN: in_ready = FIFO not full; descriptor accepted on in_valid&&in_ready; encoded word enters FIFO on the next clock edge (1-cycle latency).
REQ-022 Accepted illegal op_sel: no FIFO entry, err <= 1; in_last still honoured.
REQ-023 Accepted in_last -> DRAIN; DRAIN -> DONE when FIFO empty and no write pending; DONE lasts one cycle with done=1, then IDLE.
REQ-024 imem_we = FIFO not empty; imem_wdata = FIFO head; write completes on imem_we&&imem_ready: pop head, imem_addr += 1, count += 1.
REQ-025 imem_addr wraps modulo 2^AW; wrap is not an error.
REQ-026 Simultaneous push and pop on a full FIFO is legal; in_ready computed from current occupancy only (no same-cycle bypass).
REQ-027 start while busy is ignored.
REQ-028 busy = 1 in RUN and DRAIN, else 0.

Reset
REQ-029 rst_n low at any time, including mid-session: state IDLE, FIFO emptied, in-flight words discarded, imem_we=0, in_ready=0, imem_addr=0, count=0, busy=0, done=0, err=0.
REQ-030 Outputs hold reset values until the first clk edge after rst_n deasserts; no write issued during reset.

Verification
REQ-031 start, base_addr=0x010, ADD(op 0) rs=1 rt=2 rd=3, imem_ready=1 -> imem_wdata=0x00221820 at addr 0x010, count=1, done pulse.
REQ-032 ADDI rs=0 rt=8 imm=0xFFFF, then LUI rs=5 rt=9 imm=0x1234, then J target=0x0000040 (last) -> words 0x2008FFFF, 0x3C091234, 0x08000040 at consecutive addresses.
REQ-033 imem_ready=0 for 10 cycles with continuous in_valid -> in_ready drops after exactly DEPTH accepts; no word lost or reordered when imem_ready returns.
REQ-034 base_addr=2^AW-1, two descriptors -> writes at 0x3FF then 0x000.
REQ-035 op_sel=30 with in_last -> err=1, no imem write, done pulse, count=0.
REQ-036 rst_n low with 3 words buffered -> imem_we=0 immediately; after release, new session writes only new words.
